// File: rtl/shared_pkg.sv
// Shared constants for the sync_fifo block and its stimulus.
// Default geometry and the all-ones data pattern.
package shared_pkg;

   localparam int FIFO_WIDTH_DEF = 16;
   localparam int FIFO_DEPTH_DEF = 8;

   localparam logic [FIFO_WIDTH_DEF-1:0] max_val = {FIFO_WIDTH_DEF{1'b1}};

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: synchronous write port and a
// registered read port, neither of which is reset.
module sync_fifo_mem
   import shared_pkg::*;
#(
   parameter int WIDTH = FIFO_WIDTH_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Read register holds its value when re_i is low.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, handshake status
// and occupancy flags around the sync_fifo_mem storage array.
module sync_fifo
   import shared_pkg::*;
#(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = AW + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty
);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_ack_q, wr_ack_d;
   logic          ovf_q, ovf_d;
   logic          udf_q, udf_d;
   logic          dvalid_q, dvalid_d;
   logic          wr_acc, rd_acc;
   logic [FIFO_WIDTH-1:0] rdata;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full        = (count_q == CW'(FIFO_DEPTH));
   assign empty       = (count_q == '0);
   assign almostfull  = (count_q == CW'(FIFO_DEPTH - 1));
   assign almostempty = (count_q == CW'(1));

   // A full FIFO with a concurrent read still rejects the write.
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   always_comb begin
      wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ack_d = wr_acc;
      ovf_d    = wr_en && full;
      udf_d    = rd_en && empty;
      dvalid_d = dvalid_q || rd_acc;
      count_d  = count_q;
      unique case (1'b1)
         (wr_acc && !rd_acc): count_d = count_q + 1'b1;
         (rd_acc && !wr_acc): count_d = count_q - 1'b1;
         default:             count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         wr_ack_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         dvalid_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wr_ack_q <= wr_ack_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         dvalid_q <= dvalid_d;
      end
   end

   sync_fifo_mem #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (data_in),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q),
      .rdata_o (rdata)
   );

   // The unreset read register is masked to zero until a read lands.
   assign data_out  = dvalid_q ? rdata : '0;
   assign wr_ack    = wr_ack_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

endmodule
